// File: rtl/elevator_door_ctrl.sv
// Elevator door sequencer: CLOSED -> OPENING -> OPEN (OVERLOAD) -> CLOSING with
// a per-state down-counter timer, reversal on obstruction and a depart pulse.
module elevator_door_ctrl #(
  parameter int unsigned OPEN_TIME  = 8,
  parameter int unsigned CLOSE_TIME = 8,
  parameter int unsigned DWELL_TIME = 32
) (
  input  logic       clk,
  input  logic       weight_flip_reset,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       weight_limit_exceeded,
  output logic       door,
  output logic       opening,
  output logic       closing,
  output logic       alarm,
  output logic       depart_ok,
  output logic [2:0] state
);

  localparam logic [2:0] S_CLOSED   = 3'd0;
  localparam logic [2:0] S_OPENING  = 3'd1;
  localparam logic [2:0] S_OPEN     = 3'd2;
  localparam logic [2:0] S_OVERLOAD = 3'd3;
  localparam logic [2:0] S_CLOSING  = 3'd4;

  // Timer holds "cycles left after this one", so a duration N loads N-1;
  // a zero duration is treated as one cycle and anything above 255 clips.
  function automatic logic [7:0] load_val(input int unsigned t);
    int unsigned c;
    if (t == 0)        c = 1;
    else if (t > 255)  c = 255;
    else               c = t;
    return 8'(c - 1);
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] t);
    return (t == 8'd0) ? 8'd0 : t - 8'd1;
  endfunction

  localparam logic [7:0] OPEN_LD  = load_val(OPEN_TIME);
  localparam logic [7:0] CLOSE_LD = load_val(CLOSE_TIME);
  localparam logic [7:0] DWELL_LD = load_val(DWELL_TIME);

  logic [1:0] rst_sync;
  logic       rst_hold;
  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;

  // Reset asserts immediately but releases through two flops, so the FSM
  // keeps CLOSED until the release has been seen on two rising edges.
  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) rst_sync <= 2'b11;
    else                   rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_hold = rst_sync[1];

  always_ff @(posedge clk or posedge weight_flip_reset) begin
    if (weight_flip_reset) begin
      state_q   <= S_CLOSED;
      timer_q   <= 8'd0;
      depart_ok <= 1'b0;
    end else if (rst_hold) begin
      state_q   <= S_CLOSED;
      timer_q   <= 8'd0;
      depart_ok <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      depart_ok <= (state_q == S_CLOSING) && (state_d == S_CLOSED);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = sat_dec(timer_q);
    case (state_q)
      S_CLOSED: begin
        if (arrive || open_btn) begin
          state_d = S_OPENING;
          timer_d = OPEN_LD;
        end else begin
          timer_d = 8'd0;
        end
      end
      S_OPENING: begin
        if (timer_q == 8'd0) begin
          state_d = S_OPEN;
          timer_d = DWELL_LD;
        end
      end
      S_OPEN: begin
        if (weight_limit_exceeded) begin
          state_d = S_OVERLOAD;
          timer_d = 8'd0;
        end else if (open_btn) begin
          timer_d = DWELL_LD;
        end else if (close_btn || (timer_q == 8'd0)) begin
          state_d = S_CLOSING;
          timer_d = CLOSE_LD;
        end
      end
      S_OVERLOAD: begin
        if (!weight_limit_exceeded) begin
          state_d = S_OPEN;
          timer_d = DWELL_LD;
        end else begin
          timer_d = 8'd0;
        end
      end
      S_CLOSING: begin
        if (open_btn || arrive || weight_limit_exceeded) begin
          state_d = S_OPENING;
          timer_d = OPEN_LD;
        end else if (timer_q == 8'd0) begin
          state_d = S_CLOSED;
          timer_d = 8'd0;
        end
      end
      default: begin
        state_d = S_CLOSED;
        timer_d = 8'd0;
      end
    endcase
  end

  always_comb begin
    door    = 1'b0;
    opening = 1'b0;
    closing = 1'b0;
    alarm   = 1'b0;
    case (state_q)
      S_OPENING:  opening = 1'b1;
      S_OPEN:     door    = 1'b1;
      S_OVERLOAD: begin
        door  = 1'b1;
        alarm = 1'b1;
      end
      S_CLOSING:  closing = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_elevator_door_ctrl.sv
// Bench for elevator_door_ctrl: directed vector table, reset corner cases and
// randomized traffic against an elapsed-cycle reference model.
module tb_elevator_door_ctrl;

  localparam int OT = 8;
  localparam int CT = 8;
  localparam int DT = 32;
  localparam int CL = 0, OG = 1, OP = 2, OV = 3, CG = 4;

  logic       clk = 1'b0;
  logic       weight_flip_reset = 1'b1;
  logic       arrive = 1'b0, open_btn = 1'b0, close_btn = 1'b0, weight_limit_exceeded = 1'b0;
  logic       door, opening, closing, alarm, depart_ok;
  logic [2:0] state;
  logic [7:0] dut_vec;

  int checks = 0;
  int errors = 0;

  elevator_door_ctrl dut (
    .clk(clk),
    .weight_flip_reset(weight_flip_reset),
    .arrive(arrive),
    .open_btn(open_btn),
    .close_btn(close_btn),
    .weight_limit_exceeded(weight_limit_exceeded),
    .door(door),
    .opening(opening),
    .closing(closing),
    .alarm(alarm),
    .depart_ok(depart_ok),
    .state(state)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, door, opening, closing, alarm, depart_ok};

  typedef struct {
    bit a, o, c, w;
    int n;
    int st;
    bit dep;
  } row_t;

  row_t tbl[$];

  function automatic logic [7:0] exp_vec(input int st, input bit dep);
    return {3'(st), (st == OP || st == OV), (st == OG), (st == CG), (st == OV), dep};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st/door/opn/cls/alm/dep=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit a, input bit o, input bit c, input bit w,
                     input int n, input int st, input bit dep);
    row_t r;
    r.a = a; r.o = o; r.c = c; r.w = w; r.n = n; r.st = st; r.dep = dep;
    tbl.push_back(r);
  endtask

  task automatic drive(input bit a, input bit o, input bit c, input bit w);
    arrive = a; open_btn = o; close_btn = c; weight_limit_exceeded = w;
  endtask

  // Reference model: tracks how many cycles have been spent in the current
  // state and compares that against the configured durations.
  int m_st = CL;
  int m_el = 0;
  bit m_dep = 1'b0;

  function automatic void model_step(input bit a, input bit o, input bit c, input bit w);
    int nst;
    nst = m_st;
    m_dep = 1'b0;
    case (m_st)
      CL: if (a || o) nst = OG;
      OG: if (m_el >= OT) nst = OP;
      OP: begin
        if (w) nst = OV;
        else if (o) m_el = 0;
        else if (c || m_el >= DT) nst = CG;
      end
      OV: if (!w) nst = OP;
      CG: begin
        if (o || a || w) nst = OG;
        else if (m_el >= CT) begin
          nst = CL;
          m_dep = 1'b1;
        end
      end
      default: nst = CL;
    endcase
    if (nst != m_st) m_el = 1;
    else m_el++;
    m_st = nst;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    weight_flip_reset = 1'b1;
    drive(0, 0, 0, 0);
    @(negedge clk);
    weight_flip_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bit a, o, c, w;
    bit seen;

    // Reset state
    #1;
    check("reset_vec", dut_vec, 8'd0);
    @(posedge clk); #1;
    check("reset_hold", dut_vec, 8'd0);
    do_reset();
    check("post_reset_idle", dut_vec, 8'd0);

    // Directed vector table (durations from default parameters)
    add(1,0,0,0, 1, OG,0); add(0,0,0,0, 7, OG,0); add(0,0,0,0,32, OP,0);
    add(0,0,0,0, 8, CG,0); add(0,0,0,0, 1, CL,1); add(0,0,0,0, 4, CL,0);
    // dwell reload by open_btn at dwell cycle 20
    add(1,0,0,0, 1, OG,0); add(0,0,0,0, 7, OG,0); add(0,0,0,0,20, OP,0);
    add(0,1,0,0, 1, OP,0); add(0,0,0,0,31, OP,0); add(0,0,0,0, 8, CG,0);
    add(0,0,0,0, 1, CL,1); add(0,0,0,0, 2, CL,0);
    // overload with close_btn held
    add(1,0,0,0, 1, OG,0); add(0,0,0,0, 7, OG,0); add(0,0,0,0, 5, OP,0);
    add(0,0,1,1,50, OV,0); add(0,0,0,0,32, OP,0); add(0,0,0,0, 8, CG,0);
    add(0,0,0,0, 1, CL,1); add(0,0,0,0, 2, CL,0);
    // reversal by open_btn at closing cycle 5
    add(1,0,0,0, 1, OG,0); add(0,0,0,0, 7, OG,0); add(0,0,0,0,32, OP,0);
    add(0,0,0,0, 5, CG,0); add(0,1,0,0, 1, OG,0); add(0,0,0,0, 7, OG,0);
    add(0,0,0,0,32, OP,0); add(0,0,0,0, 8, CG,0); add(0,0,0,0, 1, CL,1);
    // both buttons: open wins in CLOSED and OPEN
    add(0,1,1,0, 1, OG,0); add(0,0,0,0, 7, OG,0); add(0,0,0,0, 3, OP,0);
    add(0,1,1,0, 1, OP,0); add(0,0,0,0,31, OP,0); add(0,0,0,0, 8, CG,0);
    add(0,0,0,0, 1, CL,1); add(0,0,0,0, 2, CL,0);
    // inputs ignored while opening, close_btn in OPEN, overload reversal
    add(1,0,0,0, 1, OG,0); add(1,1,1,1, 7, OG,0); add(0,0,0,0, 2, OP,0);
    add(0,0,1,0, 1, CG,0); add(0,0,0,0, 2, CG,0); add(0,0,0,1, 1, OG,0);
    add(0,0,0,0, 7, OG,0); add(0,0,0,0,32, OP,0); add(0,0,0,0, 8, CG,0);
    add(0,0,0,0, 1, CL,1); add(0,0,0,0, 3, CL,0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].a, tbl[i].o, tbl[i].c, tbl[i].w);
        @(posedge clk); #1;
        check($sformatf("row%0d_cyc%0d", i, k), dut_vec, exp_vec(tbl[i].st, tbl[i].dep));
      end
    end
    drive(0, 0, 0, 0);

    // Async reset mid-OPENING: immediate clear, no depart pulse afterwards
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("opening_before_reset", dut_vec, exp_vec(OG, 0));
    #2 weight_flip_reset = 1'b1;
    #1 check("async_reset_clear", dut_vec, 8'd0);
    #1 weight_flip_reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check($sformatf("after_reset_idle%0d", k), dut_vec, 8'd0);
    end

    // Reset release synchronisation: no state change on the first edge
    @(negedge clk);
    weight_flip_reset = 1'b1;
    @(negedge clk);
    weight_flip_reset = 1'b0;
    drive(1, 0, 0, 0);
    @(posedge clk); #1;
    check("release_edge1", dut_vec, 8'd0);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(posedge clk); #1;
      if (state == 3'(OG)) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL release_open: state %0d, required %0d within 5 edges", state, OG);
    end
    do_reset();

    // Randomized traffic against the reference model
    m_st = CL; m_el = 0; m_dep = 1'b0;
    w = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      a = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 11) == 0);
      c = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 39) == 0) w = ~w;
      drive(a, o, c, w);
      @(posedge clk);
      model_step(a, o, c, w);
      #1;
      check($sformatf("rand%0d", k), dut_vec, exp_vec(m_st, m_dep));
    end
    drive(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
